mult_controller: RTL and testbench

// - Control and accumulate stage of the sequential signed multiplier. It sits directly downstream of shift_left and consumes its shifted-multiplicand output.
// - Converts the signed operands to magnitudes, then drives shift_left's load and en.
// - Walks the multiplier magnitude LSB-first. Adds shl_out into a 2W-1 bit accumulator whenever the current multiplier bit is 1.
// - Applies the product sign at the end and presents a signed 2W-bit product with a done pulse.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/magnitude.sv | 18 +
 rtl/mult_controller.sv | 132 +++++++++++++
 tb/tb_mult_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier controller.
//   MULT_W      default operand width
//   state_t     controller FSM states
//   cnt_width   width of the RUN-phase bit counter for a given operand width
package mult_pkg;

  localparam int unsigned MULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_SIGN = 2'd3
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned MULT_CNT_W = cnt_width(MULT_W);

endpackage

// File: rtl/magnitude.sv
// Two's-complement magnitude extractor.
//   x    in   W   signed operand
//   mag  out  W   unsigned |x|; the most negative value maps to 2^(W-1)
//   neg  out  1   sign bit of x
module magnitude
  import mult_pkg::*;
#(
  parameter int unsigned W = MULT_W
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag,
  output logic         neg
);

  assign neg = x[W-1];
  assign mag = neg ? -x : x;

endmodule

// File: rtl/mult_controller.sv
// Control and accumulate stage of the sequential signed multiplier.
// Converts operands to magnitudes, drives the external shift_left block and
// accumulates its shifted multiplicand for each set multiplier bit (LSB first),
// then applies the product sign.
//   clk, rst_n     clock / async active-low reset
//   start          request, sampled only in IDLE
//   multiplicand   signed operand A (W)
//   multiplier     signed operand B (W)
//   shl_in         |A| to shift_left (W)
//   shl_load       load strobe to shift_left
//   shl_en         shift enable to shift_left
//   shl_out        shifted magnitude from shift_left (2W-1)
//   product        signed result (2W), held until the next accepted start
//   busy           high from the accept cycle through SIGN
//   done           one-cycle pulse when product becomes valid
module mult_controller
  import mult_pkg::*;
#(
  parameter int unsigned W = MULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [W-1:0]   shl_in,
  output logic           shl_load,
  output logic           shl_en,
  input  logic [2*W-2:0] shl_out,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW = cnt_width(W);

  state_t         state, state_nxt;
  logic [W-1:0]   mag_a, mag_b;
  logic           sgn_a, sgn_b;
  logic [W-1:0]   mreg;
  logic [2*W-2:0] acc;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           run_last;

  magnitude #(.W(W)) u_mag_a (
    .x   (multiplicand),
    .mag (mag_a),
    .neg (sgn_a)
  );

  magnitude #(.W(W)) u_mag_b (
    .x   (multiplier),
    .mag (mag_b),
    .neg (sgn_b)
  );

  assign run_last = (cnt == CW'(W - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = ST_LOAD;
      ST_LOAD:               state_nxt = ST_RUN;
      ST_RUN:  if (run_last) state_nxt = ST_SIGN;
      ST_SIGN:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Shifter strobes are decoded from state alone
  always_comb begin
    shl_load = 1'b0;
    shl_en   = 1'b0;
    case (state)
      ST_LOAD: shl_load = 1'b1;
      ST_RUN:  shl_en   = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shl_in  <= '0;
      mreg    <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shl_in <= mag_a;
            mreg   <= mag_b;
            neg    <= sgn_a ^ sgn_b;
            busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          acc <= '0;
          cnt <= '0;
        end
        ST_RUN: begin
          // shl_out already holds |A| << cnt, aligned with mreg[0]
          if (mreg[0]) acc <= acc + shl_out;
          mreg <= mreg >> 1;
          cnt  <= cnt + CW'(1);
        end
        ST_SIGN: begin
          // negating a zero magnitude yields zero, so no special case needed
          product <= neg ? -{1'b0, acc} : {1'b0, acc};
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_controller.sv
// Directed self-checking bench for mult_controller with a behavioural
// shift_left alongside it (load |A| zero-extended, then shift left by one per enable).
module tb_mult_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic [7:0]  shl_in;
  logic        shl_load, shl_en;
  logic [14:0] shl_out;
  logic [15:0] product;
  logic        busy, done;

  int vectors;
  int miscompares;

  mult_controller #(.W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .shl_in       (shl_in),
    .shl_load     (shl_load),
    .shl_en       (shl_en),
    .shl_out      (shl_out),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  // shift_left as wired in the multiplier top
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        shl_out <= '0;
    else if (shl_load) shl_out <= {7'b0, shl_in};
    else if (shl_en)   shl_out <= shl_out << 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    vectors++; if (product !== 16'h0000) begin miscompares++; $display("FAIL reset_product: got %h expected 0000", product); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (shl_load !== 1'b0 || shl_en !== 1'b0) begin miscompares++; $display("FAIL reset_strobes: got load=%b en=%b expected 0 0", shl_load, shl_en); end
    vectors++; if (shl_in !== 8'h00) begin miscompares++; $display("FAIL reset_shl_in: got %h expected 00", shl_in); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // A=5, B=3: checks cycle-by-cycle busy/strobes and the 10-cycle latency
  task automatic test_latency();
    int cyc;
    bit seen;
    @(negedge clk); start = 1'b1; a = 8'd5; b = 8'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0; a = 8'h5A; b = 8'hA5;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy_c0: got %b expected 1", busy); end
    vectors++; if (shl_load !== 1'b1) begin miscompares++; $display("FAIL lat_load_c0: got %b expected 1", shl_load); end
    vectors++; if (shl_in !== 8'd5) begin miscompares++; $display("FAIL lat_shl_in: got %h expected 05", shl_in); end
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (done) seen = 1'b1;
      else begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy_c%0d: got %b expected 1", cyc, busy); end
        vectors++; if (shl_en !== (cyc <= 8)) begin miscompares++; $display("FAIL lat_en_c%0d: got %b expected %b", cyc, shl_en, (cyc <= 8)); end
        vectors++; if (shl_load !== 1'b0) begin miscompares++; $display("FAIL lat_load_c%0d: got %b expected 0", cyc, shl_load); end
      end
    end
    vectors++; if (!seen || cyc != 10) begin miscompares++; $display("FAIL lat_done_cycle: got %0d (seen=%0d) expected 10", cyc, seen); end
    vectors++; if (product !== 16'd15) begin miscompares++; $display("FAIL lat_product: got %h expected 000f", product); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL lat_busy_done: got %b expected 0", busy); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL lat_done_pulse: got %b expected 0", done); end
    vectors++; if (product !== 16'd15) begin miscompares++; $display("FAIL lat_product_hold: got %h expected 000f", product); end
  endtask

  task automatic test_products();
    logic [7:0]  ta [8];
    logic [7:0]  tbv [8];
    logic [15:0] te [8];
    int cyc;
    bit seen;
    ta[0] = 8'd5;    tbv[0] = 8'd3;    te[0] = 16'h000F;
    ta[1] = 8'hF9;   tbv[1] = 8'd6;    te[1] = 16'hFFD6;  // -7 * 6
    ta[2] = 8'd7;    tbv[2] = 8'hFA;   te[2] = 16'hFFD6;  // 7 * -6
    ta[3] = 8'h80;   tbv[3] = 8'h80;   te[3] = 16'h4000;  // -128 * -128
    ta[4] = 8'h80;   tbv[4] = 8'd1;    te[4] = 16'hFF80;  // -128 * 1
    ta[5] = 8'd0;    tbv[5] = 8'hFB;   te[5] = 16'h0000;  // 0 * -5
    ta[6] = 8'hFF;   tbv[6] = 8'hFF;   te[6] = 16'h0001;  // -1 * -1
    ta[7] = 8'd127;  tbv[7] = 8'h80;   te[7] = 16'hC080;  // 127 * -128
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); start = 1'b1; a = ta[i]; b = tbv[i];
      @(posedge clk); @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      seen = 1'b0; cyc = 0;
      while (!seen && cyc < 20) begin
        @(posedge clk); @(negedge clk); cyc++;
        if (done) seen = 1'b1;
      end
      vectors++; if (!seen || cyc != 10) begin miscompares++; $display("FAIL prod_latency[%0d]: got %0d (seen=%0d) expected 10", i, cyc, seen); end
      vectors++; if (product !== te[i]) begin miscompares++; $display("FAIL product[%0d]: got %h expected %h", i, product, te[i]); end
      @(negedge clk);
      vectors++; if (done !== 1'b0 || product !== te[i]) begin miscompares++; $display("FAIL prod_hold[%0d]: got done=%b %h expected done=0 %h", i, done, product, te[i]); end
    end
  endtask

  // start pulses mid-operation must not restart or add a done
  task automatic test_start_ignored();
    int ndone, dcyc;
    logic [15:0] pr;
    ndone = 0; dcyc = -1; pr = '0;
    @(negedge clk); start = 1'b1; a = 8'd9; b = 8'd11;
    @(posedge clk); @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); @(negedge clk);
      start = (cyc == 3 || cyc == 6);
      if (done) begin ndone++; dcyc = cyc; pr = product; end
    end
    start = 1'b0;
    vectors++; if (ndone != 1) begin miscompares++; $display("FAIL ign_done_count: got %0d expected 1", ndone); end
    vectors++; if (dcyc != 10) begin miscompares++; $display("FAIL ign_done_cycle: got %0d expected 10", dcyc); end
    vectors++; if (pr !== 16'h0063) begin miscompares++; $display("FAIL ign_product: got %h expected 0063", pr); end
  endtask

  // start held high: re-accepted on the first IDLE cycle after done
  task automatic test_back_to_back();
    int ndone, d1, d2;
    logic [15:0] p1, p2;
    ndone = 0; d1 = -1; d2 = -1; p1 = '0; p2 = '0;
    @(negedge clk); start = 1'b1; a = 8'd2; b = 8'd3;
    @(posedge clk); @(negedge clk); a = 8'hFC; b = 8'd5;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1 = cyc; p1 = product; end
        else if (ndone == 2) begin d2 = cyc; p2 = product; end
      end
      if (cyc == 21) start = 1'b0;
    end
    start = 1'b0;
    vectors++; if (ndone != 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    vectors++; if (d1 != 10 || p1 !== 16'h0006) begin miscompares++; $display("FAIL b2b_first: got cyc=%0d %h expected cyc=10 0006", d1, p1); end
    vectors++; if (d2 != 21 || p2 !== 16'hFFEC) begin miscompares++; $display("FAIL b2b_second: got cyc=%0d %h expected cyc=21 ffec", d2, p2); end
  endtask

  // reset mid-run clears outputs at once, no done, then a fresh op works
  task automatic test_abort();
    int ndone, cyc;
    bit seen;
    @(negedge clk); start = 1'b1; a = 8'd100; b = 8'd100;
    @(posedge clk); @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 5; c++) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (product !== 16'h0000) begin miscompares++; $display("FAIL abort_product: got %h expected 0000", product); end
    vectors++; if (done !== 1'b0 || shl_load !== 1'b0 || shl_en !== 1'b0) begin miscompares++; $display("FAIL abort_strobes: got done=%b load=%b en=%b expected 0 0 0", done, shl_load, shl_en); end
    vectors++; if (shl_in !== 8'h00) begin miscompares++; $display("FAIL abort_shl_in: got %h expected 00", shl_in); end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); @(negedge clk);
      if (done) ndone++;
    end
    vectors++; if (ndone != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    @(negedge clk); start = 1'b1; a = 8'hFD; b = 8'd25;
    @(posedge clk); @(negedge clk); start = 1'b0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (done) seen = 1'b1;
    end
    vectors++; if (!seen || cyc != 10) begin miscompares++; $display("FAIL abort_fresh_latency: got %0d (seen=%0d) expected 10", cyc, seen); end
    vectors++; if (product !== 16'hFFB5) begin miscompares++; $display("FAIL abort_fresh_product: got %h expected ffb5", product); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_latency();
    test_products();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
